// File: rtl/saturn_alu_pkg.sv
// Shared definitions for the Saturn nibble ALU: op codes, FSM states, nibble width.
// Decimal (BCD) arithmetic is enabled with the macro SATURN_ALU_DECIMAL_EN.
package saturn_alu_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [2:0] {
        OP_ZERO = 3'd0,
        OP_COPY = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_INC  = 3'd4,
        OP_DEC  = 3'd5,
        OP_NEG  = 3'd6,
        OP_EXCH = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/saturn_nibble_adder.sv
// One-nibble add/subtract with carry/borrow; BCD adjust only under SATURN_ALU_DECIMAL_EN.
module saturn_nibble_adder
    import saturn_alu_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             dec,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    // Five-bit result: bit 4 is carry for add, sign (borrow) for subtract.
    logic [NIB_W:0] raw;

    always_comb begin
        if (sub) begin
            raw = {1'b0, a} - {1'b0, b} - {{NIB_W{1'b0}}, cin};
        end else begin
            raw = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};
        end
    end

`ifdef SATURN_ALU_DECIMAL_EN
    logic [NIB_W:0] adj;

    always_comb begin
        adj  = raw;
        cout = raw[NIB_W];
        if (dec) begin
            if (sub) begin
                if (raw[NIB_W]) begin
                    adj = raw + 5'd10;
                end
            end else if (raw >= 5'd10) begin
                adj  = raw - 5'd10;
                cout = 1'b1;
            end
        end
        sum = adj[NIB_W-1:0];
    end
`else
    logic unused_dec;
    assign unused_dec = dec;
    assign sum        = raw[NIB_W-1:0];
    assign cout       = raw[NIB_W];
`endif

endmodule

// File: rtl/saturn_alu_nibble_engine.sv
// Nibble-serial field ALU: processes one nibble per cycle from field start to last, wrapping.
// Optional BCD arithmetic is enabled with the macro SATURN_ALU_DECIMAL_EN.
module saturn_alu_nibble_engine
    import saturn_alu_pkg::*;
#(
    parameter int NIBBLES = 16,
    parameter int W       = 4 * NIBBLES
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic [2:0]   i_op,
    input  logic [3:0]   i_field_start,
    input  logic [3:0]   i_field_last,
    input  logic         i_dec,
    input  logic [W-1:0] i_src1,
    input  logic [W-1:0] i_src2,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_result,
    output logic         o_carry,
    output logic [1:0]   o_dbg_state
);

    localparam int PW = $clog2(NIBBLES);

    alu_state_e    state_q, state_d;
    alu_op_e       op_q, op_d;
    logic          dec_q, dec_d;
    logic [W-1:0]  src2_q, src2_d;
    logic [W-1:0]  work_q, work_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] last_q, last_d;
    logic          carry_q, carry_d;
    logic          first_q, first_d;
    logic          done_q, done_d;
    logic [W-1:0]  result_q, result_d;
    logic          cout_q, cout_d;

    logic [NIB_W-1:0] a_nib, b_nib;
    logic [NIB_W-1:0] add_a, add_b, add_sum;
    logic             add_cin, add_sub, add_cout;
    logic [NIB_W-1:0] nib_res;
    logic             nib_cout;

    // Untouched nibbles of work_q still hold src1, so the live nibble is read from it.
    assign a_nib = work_q[{ptr_q, 2'b00} +: NIB_W];
    assign b_nib = src2_q[{ptr_q, 2'b00} +: NIB_W];

    always_comb begin
        add_a   = a_nib;
        add_b   = b_nib;
        add_cin = carry_q;
        add_sub = 1'b0;
        case (op_q)
            OP_SUB: add_sub = 1'b1;
            OP_INC: begin
                add_b   = '0;
                add_cin = first_q | carry_q;
            end
            OP_DEC: begin
                add_b   = '0;
                add_cin = first_q | carry_q;
                add_sub = 1'b1;
            end
            OP_NEG: begin
                add_a   = '0;
                add_b   = a_nib;
                add_sub = 1'b1;
            end
            default: ;
        endcase
    end

    saturn_nibble_adder u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sub  (add_sub),
        .dec  (dec_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        nib_res  = add_sum;
        nib_cout = add_cout;
        case (op_q)
            OP_ZERO: begin
                nib_res  = '0;
                nib_cout = 1'b0;
            end
            OP_COPY, OP_EXCH: begin
                nib_res  = b_nib;
                nib_cout = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        dec_d    = dec_q;
        src2_d   = src2_q;
        work_d   = work_q;
        ptr_d    = ptr_q;
        last_d   = last_q;
        carry_d  = carry_q;
        first_d  = first_q;
        done_d   = 1'b0;
        result_d = result_q;
        cout_d   = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_RUN;
                    op_d    = alu_op_e'(i_op);
                    dec_d   = i_dec;
                    src2_d  = i_src2;
                    work_d  = i_src1;
                    ptr_d   = i_field_start[PW-1:0];
                    last_d  = i_field_last[PW-1:0];
                    carry_d = 1'b0;
                    first_d = 1'b1;
                end
            end
            ST_RUN: begin
                work_d[{ptr_q, 2'b00} +: NIB_W] = nib_res;
                carry_d = nib_cout;
                first_d = 1'b0;
                ptr_d   = ptr_q + 1'b1;
                if (ptr_q == last_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d   = 1'b1;
                result_d = work_q;
                cout_d   = carry_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ZERO;
            dec_q    <= 1'b0;
            src2_q   <= '0;
            work_q   <= '0;
            ptr_q    <= '0;
            last_q   <= '0;
            carry_q  <= 1'b0;
            first_q  <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dec_q    <= dec_d;
            src2_q   <= src2_d;
            work_q   <= work_d;
            ptr_q    <= ptr_d;
            last_q   <= last_d;
            carry_q  <= carry_d;
            first_q  <= first_d;
            done_q   <= done_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

    assign o_busy      = (state_q != ST_IDLE);
    assign o_done      = done_q;
    assign o_result    = result_q;
    assign o_carry     = cout_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_saturn_alu_nibble_engine.sv
// Randomised bench for saturn_alu_nibble_engine (16- and 4-nibble instances) against a field-level model.
module tb_saturn_alu_nibble_engine;

`ifdef SATURN_ALU_DECIMAL_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    typedef struct {
        int          start_at;
        int          done_at;
        logic [63:0] res;
        logic        cy;
    } exp_t;

    // clock / reset
    logic i_clk = 1'b0;
    logic i_reset = 1'b1;
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // 16-nibble instance
    logic        st16 = 0, dec16 = 0;
    logic [2:0]  op16 = 0;
    logic [3:0]  fs16 = 0, fl16 = 0;
    logic [63:0] s1_16 = 0, s2_16 = 0;
    logic        busy16, done16, cy16;
    logic [63:0] res16;
    logic [1:0]  dbg16;

    // 4-nibble instance
    logic        st4 = 0, dec4 = 0;
    logic [2:0]  op4 = 0;
    logic [3:0]  fs4 = 0, fl4 = 0;
    logic [15:0] s1_4 = 0, s2_4 = 0;
    logic        busy4, done4, cy4;
    logic [15:0] res4;
    logic [1:0]  dbg4;

    saturn_alu_nibble_engine u_dut16 (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(st16), .i_op(op16),
        .i_field_start(fs16), .i_field_last(fl16), .i_dec(dec16),
        .i_src1(s1_16), .i_src2(s2_16), .o_busy(busy16), .o_done(done16),
        .o_result(res16), .o_carry(cy16), .o_dbg_state(dbg16)
    );

    saturn_alu_nibble_engine #(.NIBBLES(4)) u_dut4 (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(st4), .i_op(op4),
        .i_field_start(fs4), .i_field_last(fl4), .i_dec(dec4),
        .i_src1(s1_4), .i_src2(s2_4), .o_busy(busy4), .o_done(done4),
        .o_result(res4), .o_carry(cy4), .o_dbg_state(dbg4)
    );

    // scoreboard state
    exp_t        exp16_q[$];
    exp_t        exp4_q[$];
    logic [63:0] last16 = 0, last4 = 0;
    logic        lastc16 = 0, lastc4 = 0;
    int          free16 = 0, free4 = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Field-level reference: walk the field nibble by nibble with integer arithmetic.
    function automatic void model(input int n, input int op, input int fs, input int fl,
                                  input bit dec, input logic [63:0] s1, input logic [63:0] s2,
                                  output logic [63:0] res, output logic cy, output int k);
        int s, l, base, idx, a, b, c, t, r;
        s = fs % n;
        l = fl % n;
        k = ((l - s + n) % n) + 1;
        base = dec ? 10 : 16;
        res = s1;
        c = 0;
        for (int j = 0; j < k; j++) begin
            idx = (s + j) % n;
            a = int'(s1[idx*4 +: 4]);
            b = int'(s2[idx*4 +: 4]);
            t = 0;
            case (op)
                0: begin r = 0; c = 0; end
                1, 7: begin r = b; c = 0; end
                default: begin
                    case (op)
                        2: t = a + b + c;
                        3: t = a - b - c;
                        4: t = a + ((j == 0) ? 1 : c);
                        5: t = a - ((j == 0) ? 1 : c);
                        default: t = 0 - a - c;
                    endcase
                    if (t < 0) begin r = t + base; c = 1; end
                    else if (t >= base) begin r = t - base; c = 1; end
                    else begin r = t; c = 0; end
                end
            endcase
            res[idx*4 +: 4] = 4'(r & 15);
        end
        cy = c[0];
    endfunction

    task automatic cmp(input string tag, input logic busy, input logic done,
                       input logic [63:0] res, input logic cy, input bit have, input exp_t h,
                       input logic [63:0] lr, input logic lc, output bit fired);
        bit ed, eb;
        ed = have && (h.done_at == cyc);
        eb = have && (cyc >= h.start_at) && (cyc < h.done_at);
        chk({tag, "_busy"}, 64'(busy), 64'(eb));
        chk({tag, "_done"}, 64'(done), 64'(ed));
        chk({tag, "_result"}, res, ed ? h.res : lr);
        chk({tag, "_carry"}, 64'(cy), 64'(ed ? h.cy : lc));
        fired = ed;
    endtask

    always @(negedge i_clk) begin : compare_blk
        exp_t h;
        bit   have, f;
        if (chk_en) begin
            have = exp16_q.size() > 0;
            if (have) h = exp16_q[0];
            else h = '{0, 0, 64'h0, 1'b0};
            cmp("d16", busy16, done16, res16, cy16, have, h, last16, lastc16, f);
            if (f) begin
                last16 = h.res;
                lastc16 = h.cy;
                h = exp16_q.pop_front();
            end
            have = exp4_q.size() > 0;
            if (have) h = exp4_q[0];
            else h = '{0, 0, 64'h0, 1'b0};
            cmp("d4", busy4, done4, {48'h0, res4}, cy4, have, h, last4, lastc4, f);
            if (f) begin
                last4 = h.res;
                lastc4 = h.cy;
                h = exp4_q.pop_front();
            end
        end
    end

    // drivers (called at a falling edge)
    task automatic go16(input int op, input int fs, input int fl, input bit dec,
                        input logic [63:0] s1, input logic [63:0] s2);
        logic [63:0] r;
        logic        c;
        int          k;
        exp_t        e;
        while (cyc < free16) @(negedge i_clk);
        model(16, op, fs, fl, dec && DEC_EN, s1, s2, r, c, k);
        st16 = 1; op16 = 3'(op); fs16 = 4'(fs); fl16 = 4'(fl); dec16 = dec;
        s1_16 = s1; s2_16 = s2;
        e.start_at = cyc + 1;
        e.done_at = cyc + 2 + k;
        e.res = r;
        e.cy = c;
        exp16_q.push_back(e);
        free16 = e.done_at;
        @(negedge i_clk);
        st16 = 0;
    endtask

    task automatic go4(input int op, input int fs, input int fl, input bit dec,
                       input logic [15:0] s1, input logic [15:0] s2);
        logic [63:0] r;
        logic        c;
        int          k;
        exp_t        e;
        while (cyc < free4) @(negedge i_clk);
        model(4, op, fs, fl, dec && DEC_EN, {48'h0, s1}, {48'h0, s2}, r, c, k);
        st4 = 1; op4 = 3'(op); fs4 = 4'(fs); fl4 = 4'(fl); dec4 = dec;
        s1_4 = s1; s2_4 = s2;
        e.start_at = cyc + 1;
        e.done_at = cyc + 2 + k;
        e.res = r;
        e.cy = c;
        exp4_q.push_back(e);
        free4 = e.done_at;
        @(negedge i_clk);
        st4 = 0;
    endtask

    // start pulse while the 16-nibble engine is busy; must be ignored
    task automatic poke16();
        st16 = 1; op16 = 3'($urandom_range(0, 7));
        fs16 = 4'($urandom_range(0, 15)); fl16 = 4'($urandom_range(0, 15));
        s1_16 = {$urandom, $urandom}; s2_16 = {$urandom, $urandom};
        @(negedge i_clk);
        st16 = 0;
    endtask

    task automatic do_reset(input bit with_start);
        i_reset = 1;
        if (with_start) begin
            st16 = 1; op16 = 3'd2; fs16 = 0; fl16 = 3;
            s1_16 = {$urandom, $urandom}; s2_16 = {$urandom, $urandom};
        end
        @(posedge i_clk);
        #1;
        exp16_q.delete();
        exp4_q.delete();
        last16 = 0; lastc16 = 0; last4 = 0; lastc4 = 0;
        free16 = 0; free4 = 0;
        @(negedge i_clk);
        i_reset = 0;
        st16 = 0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [63:0] r;
        logic        c;
        int          k;

        // model pins, hand-computed
        model(16, 2, 0, 4, 0, 64'h00000000000FFFFF, 64'h1, r, c, k);
        chk("pin_add_res", r, 64'h0); chk("pin_add_cy", 64'(c), 64'h1); chk("pin_add_k", 64'(k), 64'd5);
        model(16, 1, 14, 1, 0, 64'h0, 64'hFFFFFFFFFFFFFFFF, r, c, k);
        chk("pin_wrap_res", r, 64'hFF000000000000FF); chk("pin_wrap_k", 64'(k), 64'd4);
        model(16, 2, 0, 1, 0, 64'h58, 64'h47, r, c, k);
        chk("pin_hexadd_res", r, 64'h9F); chk("pin_hexadd_cy", 64'(c), 64'h0);
        model(16, 2, 0, 1, 1, 64'h58, 64'h47, r, c, k);
        chk("pin_bcdadd_res", r, 64'h05); chk("pin_bcdadd_cy", 64'(c), 64'h1);
        model(16, 3, 0, 3, 0, 64'h0, 64'h1, r, c, k);
        chk("pin_hexsub_res", r, 64'hFFFF); chk("pin_hexsub_cy", 64'(c), 64'h1);
        model(16, 3, 0, 3, 1, 64'h0, 64'h1, r, c, k);
        chk("pin_bcdsub_res", r, 64'h9999); chk("pin_bcdsub_cy", 64'(c), 64'h1);
        model(4, 4, 5, 5, 0, 64'h0F00, 64'h0, r, c, k);
        chk("pin_inc4_res", r, 64'h0F10); chk("pin_inc4_cy", 64'(c), 64'h0); chk("pin_inc4_k", 64'(k), 64'd1);

        // reset state
        repeat (3) @(negedge i_clk);
        chk("rst_busy16", 64'(busy16), 64'h0);
        chk("rst_done16", 64'(done16), 64'h0);
        chk("rst_res16", res16, 64'h0);
        chk("rst_cy16", 64'(cy16), 64'h0);
        chk("rst_res4", {48'h0, res4}, 64'h0);
        chk_en = 1;
        i_reset = 0;
        @(negedge i_clk);

        // directed vectors
        go16(2, 0, 4, 0, 64'h00000000000FFFFF, 64'h1);
        go16(1, 14, 1, 0, 64'h0, 64'hFFFFFFFFFFFFFFFF);
        go16(2, 0, 1, 1, 64'h58, 64'h47);
        go16(3, 0, 3, 0, 64'h0, 64'h1);
        go16(3, 0, 3, 1, 64'h0, 64'h1);
        go16(6, 3, 3, 0, 64'h0000000000001000, 64'h0);
        go16(5, 0, 15, 0, 64'h0, 64'h0);
        go16(7, 15, 0, 0, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210);
        go4(4, 5, 5, 0, 16'h0F00, 16'h0);
        go4(2, 3, 1, 0, 16'hFFFF, 16'h0001);

        // reset in the second RUN cycle, then normal operation and ignored start
        go16(2, 0, 4, 0, {$urandom, $urandom}, {$urandom, $urandom});
        @(negedge i_clk);
        do_reset(0);
        go16(2, 0, 4, 0, 64'h00000000000FFFFF, 64'h1);
        poke16();
        do_reset(1);
        @(negedge i_clk);

        // random traffic
        for (int i = 0; i < 150; i++) begin
            go16($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
                 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) poke16();
            repeat ($urandom_range(0, 2)) @(negedge i_clk);
        end
        for (int i = 0; i < 60; i++) begin
            go4($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
                1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
            repeat ($urandom_range(0, 1)) @(negedge i_clk);
        end

        // drain with a bounded wait
        for (int i = 0; i < 40 && (exp16_q.size() + exp4_q.size()) > 0; i++) @(negedge i_clk);
        chk("drain", 64'(exp16_q.size() + exp4_q.size()), 64'h0);
        repeat (2) @(negedge i_clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
